// File: rtl/mc_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: states, opcodes, select values.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mc_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_e;

   // Primary opcodes (IR[31:26])
   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_LUI   = 6'b001111;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_JAL   = 6'b000011;

   // R-type function codes (IR[5:0])
   localparam logic [5:0] FN_ADDU  = 6'b100001;
   localparam logic [5:0] FN_SUBU  = 6'b100011;
   localparam logic [5:0] FN_JR    = 6'b001000;

   localparam logic [1:0] NPC_PC4  = 2'd0;
   localparam logic [1:0] NPC_BR   = 2'd1;
   localparam logic [1:0] NPC_JMP  = 2'd2;
   localparam logic [1:0] NPC_REG  = 2'd3;

   localparam logic [1:0] EXT_SIGN = 2'd0;
   localparam logic [1:0] EXT_ZERO = 2'd1;
   localparam logic [1:0] EXT_LUI  = 2'd2;

   localparam logic [1:0] BSEL_RT  = 2'd0;
   localparam logic [1:0] BSEL_IMM = 2'd1;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_OR   = 4'b0011;

   localparam logic [1:0] A3_RD    = 2'd0;
   localparam logic [1:0] A3_RT    = 2'd1;
   localparam logic [1:0] A3_RA    = 2'd2;

   localparam logic [1:0] WD_ALU   = 2'd0;
   localparam logic [1:0] WD_DM    = 2'd1;
   localparam logic [1:0] WD_PC4   = 2'd2;

   typedef enum logic [3:0] {
      CL_RTYPE, CL_ORI, CL_LUI, CL_LW, CL_SW, CL_BEQ, CL_J, CL_JAL, CL_JR, CL_BAD
   } iclass_e;

   // I-type results land in rt; only R-type writes rd.
   function automatic logic wb_to_rt(input iclass_e c);
      return (c == CL_ORI) || (c == CL_LUI) || (c == CL_LW);
   endfunction

endpackage

// File: rtl/mc_ctrl_decode.sv
// Classifies the held instruction into the controller's instruction classes.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of opcode/funct.
// Ports: opcode = IR[31:26], funct = IR[5:0]; iclass = decoded class (CL_BAD if unsupported).
module mc_ctrl_decode
   import mc_ctrl_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output iclass_e    iclass
);

   always_comb begin
      iclass = CL_BAD;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               FN_ADDU, FN_SUBU: iclass = CL_RTYPE;
               FN_JR:            iclass = CL_JR;
               default:          iclass = CL_BAD;
            endcase
         end
         OP_ORI:  iclass = CL_ORI;
         OP_LUI:  iclass = CL_LUI;
         OP_LW:   iclass = CL_LW;
         OP_SW:   iclass = CL_SW;
         OP_BEQ:  iclass = CL_BEQ;
         OP_J:    iclass = CL_J;
         OP_JAL:  iclass = CL_JAL;
         default: iclass = CL_BAD;
      endcase
   end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS controller: sequences FETCH/DECODE/EXEC/MEM/WB and drives datapath selects/strobes.
// Latency: outputs combinational from state+IR; 2..5 cycles per instruction plus memory wait cycles.
// Backpressure: holds in MEM while dm_ready=0; TRAP is sticky until reset.
// Ports: clk, rst_n (async, active-low); IR/zero/dm_ready in; PC_WE, IR_WE, NPCsel, ExtOp, ALUasel,
//   ALUbsel, ALUOp, DM_RE, DM_WE, A3sel, WDsel, GRF_WE, illegal, state out.
//   With MC_CTRL_PERF_EN defined: cycle_cnt and instr_cnt performance counters are added.
module mc_ctrl_fsm
   import mc_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] IR,
   input  logic        zero,
   input  logic        dm_ready,
   output logic        PC_WE,
   output logic        IR_WE,
   output logic [1:0]  NPCsel,
   output logic [1:0]  ExtOp,
   output logic [1:0]  ALUasel,
   output logic [1:0]  ALUbsel,
   output logic [3:0]  ALUOp,
   output logic        DM_RE,
   output logic        DM_WE,
   output logic [1:0]  A3sel,
   output logic [1:0]  WDsel,
   output logic        GRF_WE,
   output logic        illegal,
   output logic [2:0]  state
`ifdef MC_CTRL_PERF_EN
   ,
   output logic [31:0] cycle_cnt,
   output logic [31:0] instr_cnt
`endif
);

   state_e  state_q, state_d;
   iclass_e iclass;
   logic    ir_unused;

   // Only opcode and funct steer control; register/immediate fields belong to the datapath.
   assign ir_unused = ^IR[25:6];

   mc_ctrl_decode u_decode (
      .opcode (IR[31:26]),
      .funct  (IR[5:0]),
      .iclass (iclass)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_FETCH;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      PC_WE   = 1'b0;
      IR_WE   = 1'b0;
      NPCsel  = NPC_PC4;
      ExtOp   = EXT_SIGN;
      ALUbsel = BSEL_RT;
      ALUOp   = ALU_ADD;
      DM_RE   = 1'b0;
      DM_WE   = 1'b0;
      A3sel   = A3_RD;
      WDsel   = WD_ALU;
      GRF_WE  = 1'b0;
      illegal = 1'b0;
      // The register already sits in FETCH during reset; gating here keeps FETCH's
      // IR/PC loads from firing while rst_n is held low.
      if (rst_n) begin
         case (state_q)
            ST_FETCH: begin
               IR_WE   = 1'b1;
               PC_WE   = 1'b1;
               state_d = ST_DECODE;
            end
            ST_DECODE: begin
               case (iclass)
                  CL_J: begin
                     PC_WE   = 1'b1;
                     NPCsel  = NPC_JMP;
                     state_d = ST_FETCH;
                  end
                  CL_JAL: begin
                     PC_WE   = 1'b1;
                     NPCsel  = NPC_JMP;
                     GRF_WE  = 1'b1;
                     A3sel   = A3_RA;
                     WDsel   = WD_PC4;
                     state_d = ST_FETCH;
                  end
                  CL_JR: begin
                     PC_WE   = 1'b1;
                     NPCsel  = NPC_REG;
                     state_d = ST_FETCH;
                  end
                  CL_BAD:  state_d = ST_TRAP;
                  default: state_d = ST_EXEC;
               endcase
            end
            ST_EXEC: begin
               state_d = ST_WB;
               case (iclass)
                  CL_RTYPE: ALUOp = (IR[5:0] == FN_SUBU) ? ALU_SUB : ALU_ADD;
                  CL_ORI: begin
                     ExtOp   = EXT_ZERO;
                     ALUbsel = BSEL_IMM;
                     ALUOp   = ALU_OR;
                  end
                  CL_LUI: begin
                     ExtOp   = EXT_LUI;
                     ALUbsel = BSEL_IMM;
                  end
                  CL_LW, CL_SW: begin
                     ALUbsel = BSEL_IMM;
                     state_d = ST_MEM;
                  end
                  CL_BEQ: begin
                     ALUOp   = ALU_SUB;
                     PC_WE   = zero;
                     NPCsel  = zero ? NPC_BR : NPC_PC4;
                     state_d = ST_FETCH;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               DM_RE = (iclass == CL_LW);
               DM_WE = (iclass == CL_SW);
               if (dm_ready) state_d = (iclass == CL_LW) ? ST_WB : ST_FETCH;
            end
            ST_WB: begin
               GRF_WE  = 1'b1;
               A3sel   = wb_to_rt(iclass) ? A3_RT : A3_RD;
               WDsel   = (iclass == CL_LW) ? WD_DM : WD_ALU;
               state_d = ST_FETCH;
            end
            ST_TRAP: illegal = 1'b1;
            default: state_d = ST_FETCH;
         endcase
      end
   end

   assign ALUasel = 2'd0;
   assign state   = state_q;

`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt_q, cycle_cnt_d;
   logic [31:0] instr_cnt_q, instr_cnt_d;

   // An instruction retires whenever the FSM re-enters FETCH; reset entry is not a retirement.
   always_comb begin
      cycle_cnt_d = cycle_cnt_q + 32'd1;
      instr_cnt_d = instr_cnt_q;
      if ((state_d == ST_FETCH) && (state_q != ST_FETCH)) instr_cnt_d = instr_cnt_q + 32'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cycle_cnt_q <= 32'd0;
         instr_cnt_q <= 32'd0;
      end else begin
         cycle_cnt_q <= cycle_cnt_d;
         instr_cnt_q <= instr_cnt_d;
      end
   end

   assign cycle_cnt = cycle_cnt_q;
   assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Bench for mc_ctrl_fsm: per-instruction expected output trace built from the instruction tables.
module tb_mc_ctrl_fsm;
   import mc_ctrl_pkg::*;

   typedef enum int {ADDU, SUBU, ORI, LUI, LW, SW, BEQ, J, JAL, JR, BADOP, BADFN, BAD3F} mn_e;

   typedef struct packed {
      logic       pc_we;
      logic       ir_we;
      logic [1:0] npcsel;
      logic [1:0] extop;
      logic [1:0] alubsel;
      logic [3:0] aluop;
      logic       dm_re;
      logic       dm_we;
      logic [1:0] a3sel;
      logic [1:0] wdsel;
      logic       grf_we;
      logic       illegal;
      logic [2:0] st;
      logic [1:0] asel;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] IR;
   logic        zero, dm_ready;
   logic        PC_WE, IR_WE, DM_RE, DM_WE, GRF_WE, illegal;
   logic [1:0]  NPCsel, ExtOp, ALUasel, ALUbsel, A3sel, WDsel;
   logic [3:0]  ALUOp;
   logic [2:0]  state;
`ifdef MC_CTRL_PERF_EN
   logic [31:0] cycle_cnt, instr_cnt;
`endif

   always #5 clk = ~clk;

   mc_ctrl_fsm dut (
      .clk(clk), .rst_n(rst_n), .IR(IR), .zero(zero), .dm_ready(dm_ready),
      .PC_WE(PC_WE), .IR_WE(IR_WE), .NPCsel(NPCsel), .ExtOp(ExtOp), .ALUasel(ALUasel),
      .ALUbsel(ALUbsel), .ALUOp(ALUOp), .DM_RE(DM_RE), .DM_WE(DM_WE), .A3sel(A3sel),
      .WDsel(WDsel), .GRF_WE(GRF_WE), .illegal(illegal), .state(state)
`ifdef MC_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt), .instr_cnt(instr_cnt)
`endif
   );

   obs_t act;
   assign act = {PC_WE, IR_WE, NPCsel, ExtOp, ALUbsel, ALUOp, DM_RE, DM_WE,
                 A3sel, WDsel, GRF_WE, illegal, state, ALUasel};

   int   total = 0;
   int   bad   = 0;
   int   ncyc  = 0;
   obs_t exp_o;
   logic exp_vld = 1'b0;
   int   m_cyc = 0, m_ins = 0;
   bit   m_live = 0;
   logic [2:0] m_prev = 3'd0;

   task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] r);
      total++;
      if (a !== r) begin
         bad++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, ncyc, a, r);
      end
   endtask

   // Single compare process: every driven cycle, after inputs settle, outputs must match the model.
   always @(negedge clk) begin
      #2;
      if (exp_vld) begin
         chk("outputs", 64'(act), 64'(exp_o));
`ifdef MC_CTRL_PERF_EN
         chk("cycle_cnt", 64'(cycle_cnt), 64'(m_cyc));
         chk("instr_cnt", 64'(instr_cnt), 64'(m_ins));
`endif
      end
   end

   function automatic obs_t idle(input state_e s);
      obs_t e;
      e    = '0;
      e.st = s;
      return e;
   endfunction

   function automatic logic rbit();
      return 1'($urandom);
   endfunction

   // One clock cycle: apply inputs and the expectation, and advance the counter model.
   task automatic drive(input logic rst, input logic [31:0] ir, input logic z,
                        input logic rdy, input obs_t e);
      @(negedge clk);
      ncyc++;
      rst_n    = rst;
      IR       = ir;
      zero     = z;
      dm_ready = rdy;
      exp_o    = e;
      exp_vld  = 1'b1;
      if (!rst) begin
         m_cyc  = 0;
         m_ins  = 0;
         m_live = 0;
      end else begin
         if (m_live) begin
            m_cyc++;
            if (e.st == ST_FETCH && m_prev != ST_FETCH) m_ins++;
         end
         m_live = 1;
      end
      m_prev = e.st;
   endtask

   function automatic logic [31:0] mk_ir(input mn_e m);
      logic [4:0]  rs, rt, rd;
      logic [15:0] imm;
      logic [5:0]  op, fn;
      rs  = 5'($urandom);
      rt  = 5'($urandom);
      rd  = 5'($urandom);
      imm = 16'($urandom);
      case (m)
         ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
         SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
         JR:    return {6'h00, rs, 15'd0, 6'h08};
         ORI:   return {6'h0d, rs, rt, imm};
         LUI:   return {6'h0f, 5'd0, rt, imm};
         LW:    return {6'h23, rs, rt, imm};
         SW:    return {6'h2b, rs, rt, imm};
         BEQ:   return {6'h04, rs, rt, imm};
         J:     return {6'h02, 26'($urandom)};
         JAL:   return {6'h03, 26'($urandom)};
         BAD3F: return {6'h3f, 26'($urandom)};
         BADOP: begin
            do op = 6'($urandom);
            while (op inside {6'h00, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h03});
            return {op, 26'($urandom)};
         end
         default: begin
            do fn = 6'($urandom);
            while (fn inside {6'h21, 6'h23, 6'h08});
            return {6'h00, rs, rt, rd, 5'($urandom), fn};
         end
      endcase
   endfunction

   // Emit the full expected cycle sequence for one instruction. w = dm_ready-low cycles,
   // zsel: 0/1 forces zero in EXEC, 2 random. abort_mem pulses reset on the first MEM cycle.
   task automatic run_instr(input mn_e m, input int w, input int zsel, input bit abort_mem,
                            output int n);
      logic [31:0] ir;
      obs_t        e;
      logic        z;
      ir = mk_ir(m);
      n  = 0;

      e = idle(ST_FETCH); e.pc_we = 1; e.ir_we = 1;
      drive(1, ir, rbit(), rbit(), e); n++;

      e = idle(ST_DECODE);
      if (m == J)   begin e.pc_we = 1; e.npcsel = 2; end
      if (m == JAL) begin e.pc_we = 1; e.npcsel = 2; e.grf_we = 1; e.a3sel = 2; e.wdsel = 2; end
      if (m == JR)  begin e.pc_we = 1; e.npcsel = 3; end
      drive(1, ir, rbit(), rbit(), e); n++;
      if (m inside {J, JAL, JR}) return;

      if (m inside {BADOP, BADFN, BAD3F}) begin
         e = idle(ST_TRAP); e.illegal = 1;
         for (int k = 0; k < 3; k++) drive(1, ir, rbit(), rbit(), e);
         #3 chk("trap_illegal", 64'(illegal), 64'd1);
         drive(0, ir, rbit(), rbit(), idle(ST_FETCH));
         return;
      end

      e = idle(ST_EXEC);
      z = (zsel == 2) ? rbit() : zsel[0];
      case (m)
         SUBU:    e.aluop = 4'b0001;
         ORI:     begin e.extop = 1; e.alubsel = 1; e.aluop = 4'b0011; end
         LUI:     begin e.extop = 2; e.alubsel = 1; end
         LW, SW:  e.alubsel = 1;
         BEQ:     begin e.aluop = 4'b0001; e.pc_we = z; e.npcsel = z ? 2'd1 : 2'd0; end
         default: ;
      endcase
      drive(1, ir, z, rbit(), e); n++;
      if (m == BEQ) return;

      if (m == LW || m == SW) begin
         for (int k = 0; k <= w; k++) begin
            e = idle(ST_MEM);
            e.dm_re = (m == LW);
            e.dm_we = (m == SW);
            drive(1, ir, rbit(), (k == w), e); n++;
            if (abort_mem) begin
               drive(0, ir, rbit(), rbit(), idle(ST_FETCH));
               return;
            end
         end
         if (m == SW) return;
      end

      e = idle(ST_WB); e.grf_we = 1;
      e.a3sel = (m == ADDU || m == SUBU) ? 2'd0 : 2'd1;
      e.wdsel = (m == LW) ? 2'd1 : 2'd0;
      drive(1, ir, rbit(), rbit(), e); n++;
   endtask

   initial begin
      int n;
      mn_e m;
      rst_n    = 1'b0;
      IR       = 32'd0;
      zero     = 1'b0;
      dm_ready = 1'b0;

      drive(0, 32'd0, 0, 0, idle(ST_FETCH));
      drive(0, 32'hfc00_0000, 1, 1, idle(ST_FETCH));
      #3;
      chk("reset_state", 64'(state), 64'(ST_FETCH));
      chk("reset_strobes", 64'({PC_WE, IR_WE, DM_RE, DM_WE, GRF_WE, illegal}), 64'd0);

      run_instr(ADDU, 0, 2, 0, n); chk("addu_cycles", 64'(n), 64'd4);
      run_instr(LW,   2, 2, 0, n); chk("lw_w2_cycles", 64'(n), 64'd7);
      run_instr(BEQ,  0, 1, 0, n); chk("beq_taken_cycles", 64'(n), 64'd3);
      run_instr(BEQ,  0, 0, 0, n); chk("beq_nt_cycles", 64'(n), 64'd3);
      run_instr(JAL,  0, 2, 0, n); chk("jal_cycles", 64'(n), 64'd2);
      run_instr(SW,   0, 2, 0, n); chk("sw_w0_cycles", 64'(n), 64'd4);
      run_instr(ORI,  0, 2, 0, n);
      run_instr(LUI,  0, 2, 0, n);
      run_instr(SUBU, 0, 2, 0, n);
      run_instr(JR,   0, 2, 0, n);
      run_instr(J,    0, 2, 0, n);
      run_instr(BAD3F, 0, 2, 0, n);
      run_instr(ADDU, 0, 2, 0, n);
      run_instr(SW,   3, 2, 1, n);
      #3;
      chk("abort_dm_we", 64'(DM_WE), 64'd0);
      chk("abort_state", 64'(state), 64'(ST_FETCH));
`ifdef MC_CTRL_PERF_EN
      chk("abort_cycle_cnt", 64'(cycle_cnt), 64'd0);
      chk("abort_instr_cnt", 64'(instr_cnt), 64'd0);
`endif

      for (int i = 0; i < 400; i++) begin
         int r;
         r = $urandom_range(0, 40);
         if (r < 10)      m = mn_e'(r);
         else if (r < 38) m = mn_e'(r % 10);
         else if (r == 38) m = BADOP;
         else             m = BADFN;
         run_instr(m, $urandom_range(0, 3), 2, ($urandom_range(0, 30) == 0), n);
      end

      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
